fifo_led_reader: RTL and testbench



---
 rtl/fifo_led_reader_pkg.sv | 8 +
 rtl/hold_timer.sv | 34 +++
 rtl/fifo_led_reader.sv | 88 ++++++++
 tb/tb_fifo_led_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_led_reader_pkg.sv
// rtl/fifo_led_reader_pkg.sv - shared state type and constants for the LED FIFO reader
package fifo_led_reader_pkg;

  localparam int WORD_COUNT_WIDTH = 8;

  typedef enum logic [2:0] {IDLE, READ, WAIT, LATCH, HOLD} reader_state_t;

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - loadable down-counter that parks at zero; doneOut flags the zero count
module hold_timer #(
  parameter int HOLD_CYCLES = 27_000_000
) (
  input  logic clkIn,
  input  logic resetIn,
  input  logic loadIn,
  output logic doneOut
);
  localparam int COUNT_WIDTH = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [COUNT_WIDTH-1:0] LOAD_VALUE = COUNT_WIDTH'(HOLD_CYCLES - 1);

  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (loadIn) begin
      count_d = LOAD_VALUE;
    end else if (count_q != '0) begin
      count_d = count_q - COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign doneOut = (count_q == '0);

endmodule

// File: rtl/fifo_led_reader.sv
// rtl/fifo_led_reader.sv - paced FIFO consumer: pops one word, shows it on the LEDs for HOLD_CYCLES, repeats
module fifo_led_reader
  import fifo_led_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 6,
  parameter int HOLD_CYCLES    = 27_000_000,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic                        clkIn,
  input  logic                        resetIn,
  input  logic                        emptyIn,
  input  logic [DATA_WIDTH-1:0]       dataIn,
  input  logic                        pauseIn,
  output logic                        readEnableOut,
  output logic [DATA_WIDTH-1:0]       ledOut,
  output logic                        busyOut,
  output logic [WORD_COUNT_WIDTH-1:0] wordCountOut
);
  localparam logic [DATA_WIDTH-1:0] LED_BLANK =
    LED_ACTIVE_LOW ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};

  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("fifo_led_reader: HOLD_CYCLES must be 1 or more");
  end

  reader_state_t                 state_q, state_d;
  logic                          rd_en_q, rd_en_d;
  logic                          busy_q, busy_d;
  logic [DATA_WIDTH-1:0]         led_q, led_d;
  logic [WORD_COUNT_WIDTH-1:0]   count_q, count_d;
  logic                          timer_load;
  logic                          timer_done;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clkIn  (clkIn),
    .resetIn(resetIn),
    .loadIn (timer_load),
    .doneOut(timer_done)
  );

  // The word is captured on the WAIT->LATCH edge, so LATCH is already the first
  // displayed cycle and the timer (loaded alongside) counts it as part of the hold.
  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    count_d    = count_q;
    timer_load = 1'b0;
    unique case (state_q)
      IDLE:    if (!emptyIn && !pauseIn) state_d = READ;
      READ:    state_d = WAIT;
      WAIT: begin
        state_d    = LATCH;
        timer_load = 1'b1;
        led_d      = LED_ACTIVE_LOW ? ~dataIn : dataIn;
        count_d    = count_q + WORD_COUNT_WIDTH'(1);
      end
      LATCH:   state_d = timer_done ? IDLE : HOLD;
      HOLD:    if (timer_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_en_d = (state_d == READ);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      led_q   <= LED_BLANK;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
      count_q <= count_d;
    end
  end

  assign readEnableOut = rd_en_q;
  assign busyOut       = busy_q;
  assign ledOut        = led_q;
  assign wordCountOut  = count_q;

endmodule

// File: tb/tb_fifo_led_reader.sv
// tb/tb_fifo_led_reader.sv - randomized self-checking bench with FIFO model and timing reference
module tb_fifo_led_reader;
  localparam int DW  = 6;
  localparam int H_A = 4;
  localparam int H_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          pause_a, pause_b;
  logic          empty_a, empty_b;
  logic [DW-1:0] data_a, data_b;
  logic          re_a, re_b, busy_a, busy_b;
  logic [DW-1:0] led_a, led_b;
  logic [7:0]    wc_a, wc_b;

  fifo_led_reader #(.DATA_WIDTH(DW), .HOLD_CYCLES(H_A), .LED_ACTIVE_LOW(1'b1)) dut_a (
    .clkIn(clk), .resetIn(rst), .emptyIn(empty_a), .dataIn(data_a), .pauseIn(pause_a),
    .readEnableOut(re_a), .ledOut(led_a), .busyOut(busy_a), .wordCountOut(wc_a)
  );

  fifo_led_reader #(.DATA_WIDTH(DW), .HOLD_CYCLES(H_B), .LED_ACTIVE_LOW(1'b0)) dut_b (
    .clkIn(clk), .resetIn(rst), .emptyIn(empty_b), .dataIn(data_b), .pauseIn(pause_b),
    .readEnableOut(re_b), .ledOut(led_b), .busyOut(busy_b), .wordCountOut(wc_b)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  bit            pend_a = 1'b0;
  bit            pend_b = 1'b0;
  logic [DW-1:0] exp_led_a;
  logic [7:0]    exp_wc_a;
  logic [DW-1:0] exp_led_b;
  logic [7:0]    exp_wc_b;

  task automatic upd_empty();
    empty_a = (qa.size() == (pend_a ? 1 : 0));
    empty_b = (qb.size() == (pend_b ? 1 : 0));
  endtask

  // Advance to the middle of the next cycle; FIFO returns a popped word the cycle after the pulse
  task automatic tick();
    @(negedge clk);
    if (pend_a) begin data_a = qa.pop_front(); pend_a = 1'b0; end
    else data_a = DW'($urandom);
    if (re_a === 1'b1) pend_a = 1'b1;
    if (pend_b) begin data_b = qb.pop_front(); pend_b = 1'b0; end
    else data_b = DW'($urandom);
    if (re_b === 1'b1) pend_b = 1'b1;
    upd_empty();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 6;
    if (led_a !== 6'b111111) begin errors++; $display("FAIL reset_led_a got %b exp %b", led_a, 6'b111111); end
    if (re_a !== 1'b0) begin errors++; $display("FAIL reset_re_a got %b exp 0", re_a); end
    if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %b exp 0", busy_a); end
    if (wc_a !== 8'd0) begin errors++; $display("FAIL reset_wc_a got %0d exp 0", wc_a); end
    if (led_b !== 6'b000000) begin errors++; $display("FAIL reset_led_b got %b exp 000000", led_b); end
    if (wc_b !== 8'd0) begin errors++; $display("FAIL reset_wc_b got %0d exp 0", wc_b); end
    rst = 1'b0;
    exp_led_a = 6'b111111; exp_wc_a = 8'd0;
    exp_led_b = 6'b000000; exp_wc_b = 8'd0;
    tick();
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    logic [DW-1:0] old_led;
    w = 6'b101010;
    old_led = exp_led_a;
    qa.push_back(w);
    upd_empty();
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks += 3;
      if (re_a !== (k == 1)) begin errors++; $display("FAIL single_re k=%0d got %b exp %b", k, re_a, (k == 1)); end
      if (busy_a !== (k < H_A + 3)) begin errors++; $display("FAIL single_busy k=%0d got %b exp %b", k, busy_a, (k < H_A + 3)); end
      if (led_a !== ((k >= 3) ? ~w : old_led)) begin
        errors++; $display("FAIL single_led k=%0d got %b exp %b", k, led_a, ((k >= 3) ? ~w : old_led));
      end
    end
    exp_led_a = ~w;
    exp_wc_a  = exp_wc_a + 8'd1;
    checks++;
    if (wc_a !== exp_wc_a) begin errors++; $display("FAIL single_wc got %0d exp %0d", wc_a, exp_wc_a); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[3];
    logic [7:0]    base;
    int            idx;
    base = exp_wc_a;
    for (int i = 0; i < 3; i++) begin
      w[i] = DW'($urandom);
      qa.push_back(w[i]);
    end
    upd_empty();
    for (int k = 1; k <= 3 * (H_A + 3) + 6; k++) begin
      tick();
      checks++;
      if (re_a !== ((k - 1) % (H_A + 3) == 0 && k <= 1 + 2 * (H_A + 3))) begin
        errors++; $display("FAIL burst_re k=%0d got %b", k, re_a);
      end
      if (k >= 3 && (k - 3) % (H_A + 3) == 0 && (k - 3) / (H_A + 3) < 3) begin
        idx = (k - 3) / (H_A + 3);
        checks += 2;
        if (led_a !== ~w[idx]) begin errors++; $display("FAIL burst_led word=%0d got %b exp %b", idx, led_a, ~w[idx]); end
        if (wc_a !== base + 8'(idx + 1)) begin errors++; $display("FAIL burst_wc word=%0d got %0d exp %0d", idx, wc_a, base + 8'(idx + 1)); end
      end
    end
    exp_led_a = ~w[2];
    exp_wc_a  = base + 8'd3;
    checks += 2;
    if (wc_a !== exp_wc_a) begin errors++; $display("FAIL burst_wc_final got %0d exp %0d", wc_a, exp_wc_a); end
    if (led_a !== exp_led_a) begin errors++; $display("FAIL burst_led_final got %b exp %b", led_a, exp_led_a); end
  endtask

  task automatic test_pause();
    logic [DW-1:0] w1, w2;
    int            pulses;
    w1 = DW'($urandom);
    w2 = ~w1;
    pause_a = 1'b1;
    qa.push_back(w1);
    qa.push_back(w2);
    upd_empty();
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (re_a === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL pause_hold_off got %0d pulses exp 0", pulses); end
    pause_a = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) begin
        checks++;
        if (re_a !== 1'b1) begin errors++; $display("FAIL pause_release_re got %b exp 1", re_a); end
      end else if (re_a === 1'b1) begin
        pulses++;
      end
      if (k == 3) begin
        checks++;
        if (led_a !== ~w1) begin errors++; $display("FAIL pause_led1 got %b exp %b", led_a, ~w1); end
      end
      if (k == 4) pause_a = 1'b1;
      if (k == H_A + 2) begin
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL pause_hold_busy got %b exp 1", busy_a); end
      end
      if (k == H_A + 3) begin
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL pause_hold_end got %b exp 0", busy_a); end
      end
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL pause_mid_hold got %0d pulses exp 0", pulses); end
    pause_a = 1'b0;
    tick();
    checks++;
    if (re_a !== 1'b1) begin errors++; $display("FAIL pause_second_re got %b exp 1", re_a); end
    for (int k = 2; k <= H_A + 3; k++) tick();
    exp_led_a = ~w2;
    exp_wc_a  = exp_wc_a + 8'd2;
    checks += 2;
    if (led_a !== exp_led_a) begin errors++; $display("FAIL pause_led2 got %b exp %b", led_a, exp_led_a); end
    if (wc_a !== exp_wc_a) begin errors++; $display("FAIL pause_wc got %0d exp %0d", wc_a, exp_wc_a); end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] w;
    w = ~exp_led_a;
    qa.push_back(w);
    upd_empty();
    tick();
    checks++;
    if (re_a !== 1'b1) begin errors++; $display("FAIL midrst_re got %b exp 1", re_a); end
    tick();
    rst = 1'b1;
    tick();
    checks += 4;
    if (led_a !== 6'b111111) begin errors++; $display("FAIL midrst_led got %b exp 111111", led_a); end
    if (wc_a !== 8'd0) begin errors++; $display("FAIL midrst_wc got %0d exp 0", wc_a); end
    if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy_a); end
    if (re_a !== 1'b0) begin errors++; $display("FAIL midrst_re_after got %b exp 0", re_a); end
    rst = 1'b0;
    exp_led_a = 6'b111111; exp_wc_a = 8'd0;
    exp_led_b = 6'b000000; exp_wc_b = 8'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (led_a !== 6'b111111 || wc_a !== 8'd0) begin
        errors++; $display("FAIL midrst_discard k=%0d got led %b wc %0d exp led 111111 wc 0", k, led_a, wc_a);
      end
    end
  endtask

  task automatic test_wrap_polarity();
    logic [DW-1:0] wb[256];
    int            last_pulse;
    int            idx;
    int            bad_gap;
    for (int i = 0; i < 256; i++) begin
      wb[i] = DW'($urandom);
      qb.push_back(wb[i]);
    end
    upd_empty();
    last_pulse = -1;
    bad_gap = 0;
    for (int k = 1; k <= 256 * (H_B + 3) + 6; k++) begin
      tick();
      if (re_b === 1'b1) begin
        if (last_pulse >= 0 && k - last_pulse != H_B + 3) bad_gap++;
        last_pulse = k;
      end
      if (k >= 3 && (k - 3) % (H_B + 3) == 0 && (k - 3) / (H_B + 3) < 256) begin
        idx = (k - 3) / (H_B + 3);
        checks += 2;
        if (led_b !== wb[idx]) begin errors++; $display("FAIL wrap_led word=%0d got %b exp %b", idx, led_b, wb[idx]); end
        if (wc_b !== 8'((idx + 1) % 256)) begin errors++; $display("FAIL wrap_wc word=%0d got %0d exp %0d", idx, wc_b, (idx + 1) % 256); end
      end
    end
    checks += 4;
    if (bad_gap !== 0) begin errors++; $display("FAIL wrap_spacing got %0d bad gaps exp 0", bad_gap); end
    if (last_pulse !== 1 + 255 * (H_B + 3)) begin errors++; $display("FAIL wrap_last_pulse got %0d exp %0d", last_pulse, 1 + 255 * (H_B + 3)); end
    if (wc_b !== 8'd0) begin errors++; $display("FAIL wrap_wc_final got %0d exp 0", wc_b); end
    if (led_b !== wb[255]) begin errors++; $display("FAIL wrap_led_final got %b exp %b", led_b, wb[255]); end
  endtask

  initial begin
    rst = 1'b1;
    pause_a = 1'b0;
    pause_b = 1'b0;
    data_a = '0;
    data_b = '0;
    empty_a = 1'b1;
    empty_b = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_pause();
    test_mid_reset();
    test_wrap_polarity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
